// File: rtl/aes_fifo_pkg.sv
// Shared widths and packer state encoding for the AES input/output FIFOs.
package aes_fifo_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned PARTIAL_W       = BLOCK_W - WORD_W;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    // Index of the next word to be placed in the block being assembled.
    typedef enum logic [1:0] {
        WORD0 = 2'd0,
        WORD1 = 2'd1,
        WORD2 = 2'd2,
        WORD3 = 2'd3
    } packer_state_e;

endpackage

// File: rtl/fifo_in_word_packer.sv
// Collects four 32-bit words, first word most significant, into one 128-bit block.
module word_packer
    import aes_fifo_pkg::*;
(
    input  logic   clk,
    input  logic   n_rst,
    input  logic   push,
    input  word_t  word,
    output block_t block,
    output logic   block_valid
);

    packer_state_e              state;
    packer_state_e              state_next;
    logic [PARTIAL_W-1:0]       partial;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= WORD0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (push) begin
            case (state)
                WORD0:   state_next = WORD1;
                WORD1:   state_next = WORD2;
                WORD2:   state_next = WORD3;
                WORD3:   state_next = WORD0;
                default: state_next = WORD0;
            endcase
        end
    end

    // The final word bypasses the partial register so the block commits on its own edge.
    always_comb begin
        block_valid = push && (state == WORD3);
        block       = {partial, word};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            partial <= '0;
        end else if (push) begin
            case (state)
                WORD0:   partial[PARTIAL_W-1 -: WORD_W]          <= word;
                WORD1:   partial[PARTIAL_W-1-WORD_W -: WORD_W]   <= word;
                WORD2:   partial[PARTIAL_W-1-2*WORD_W -: WORD_W] <= word;
                default: partial                                 <= partial;
            endcase
        end
    end

endmodule

// File: rtl/fifo_in.sv
// Word-to-block packer feeding a DEPTH-entry queue of 128-bit blocks for the cipher core.
module fifo_in
    import aes_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               write_en,
    input  logic [WORD_W-1:0]  data_in,
    input  logic               read_en,
    output logic [BLOCK_W-1:0] data_out,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   block_count
);

    block_t             slots [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               wr_ok_c;
    logic               rd_ok_c;
    logic               commit_c;
    block_t             block_c;
    logic [CNT_W-1:0]   count_next_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Acceptance uses the registered flags only.
    always_comb begin
        wr_ok_c = write_en && !fifo_full;
        rd_ok_c = read_en && !fifo_empty;
    end

    word_packer u_packer (
        .clk         (clk),
        .n_rst       (n_rst),
        .push        (wr_ok_c),
        .word        (data_in),
        .block       (block_c),
        .block_valid (commit_c)
    );

    always_comb begin
        count_next_c = block_count;
        if (commit_c && !rd_ok_c) begin
            count_next_c = block_count + CNT_W'(1);
        end else if (!commit_c && rd_ok_c) begin
            count_next_c = block_count - CNT_W'(1);
        end
    end

    // Slot storage carries no reset; contents are meaningless until committed.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            slots[wr_ptr] <= block_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_out    <= '0;
            block_count <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
        end else begin
            if (commit_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok_c) begin
                data_out <= slots[rd_ptr];
                rd_ptr   <= ptr_inc(rd_ptr);
            end
            block_count <= count_next_c;
            fifo_empty  <= (count_next_c == '0);
            fifo_full   <= (count_next_c == CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_fifo_in.sv
// Directed bench for fifo_in: stimulus queues expected post-edge state, a monitor checks it.
module tb_fifo_in;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        string        name;
        logic [127:0] data;
        logic         empty;
        logic         full;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic               tb_clk;
    logic               n_rst;
    logic               write_en;
    logic [31:0]        data_in;
    logic               read_en;
    logic [127:0]       data_out;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   block_count;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fifo_in #(.DEPTH(DEPTH)) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .write_en    (write_en),
        .data_in     (data_in),
        .read_en     (read_en),
        .data_out    (data_out),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .block_count (block_count)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    function automatic logic [127:0] blk(input logic [31:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: outputs are stable at the falling edge following each stimulus edge.
    always @(negedge tb_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".data_out"},    data_out,            e.data);
            check({e.name, ".fifo_empty"},  128'(fifo_empty),    128'(e.empty));
            check({e.name, ".fifo_full"},   128'(fifo_full),     128'(e.full));
            check({e.name, ".block_count"}, 128'(block_count),   128'(e.count));
        end
    end

    // One clock of stimulus; the expectation describes the outputs after this edge.
    task automatic step(input bit rst, input bit we, input logic [31:0] din, input bit re,
                        input logic [127:0] ed, input bit ee, input bit ef, input int ec,
                        input string nm);
        exp_t e;
        n_rst    = !rst;
        write_en = we;
        data_in  = din;
        read_en  = re;
        @(posedge tb_clk);
        e.name  = nm;
        e.data  = ed;
        e.empty = ee;
        e.full  = ef;
        e.count = CNT_W'(ec);
        sb.push_back(e);
        @(negedge tb_clk);
    endtask

    logic [127:0] b_ad, b_14, b_58, b_10, b_14b, b_20, b_30, b_36, b_41, b_45;

    initial begin
        b_ad  = blk(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
        b_14  = blk(32'h1, 32'h2, 32'h3, 32'h4);
        b_58  = blk(32'h5, 32'h6, 32'h7, 32'h8);
        b_10  = blk(32'h10, 32'h11, 32'h12, 32'h13);
        b_14b = blk(32'h14, 32'h15, 32'h16, 32'h17);
        b_20  = blk(32'h20, 32'h21, 32'h22, 32'h23);
        b_30  = blk(32'h30, 32'h31, 32'h32, 32'h33);
        b_36  = blk(32'h3, 32'h4, 32'h5, 32'h6);
        b_41  = blk(32'h41, 32'h42, 32'h43, 32'h44);
        b_45  = blk(32'h45, 32'h46, 32'h47, 32'h48);

        n_rst = 1'b0; write_en = 1'b0; data_in = '0; read_en = 1'b0;

        // reset and idle
        step(1, 0, 0, 0, '0, 1, 0, 0, "rst0");
        step(1, 1, 32'h77, 1, '0, 1, 0, 0, "rst1");
        step(0, 0, 0, 0, '0, 1, 0, 0, "idle0");
        step(0, 0, 0, 0, '0, 1, 0, 0, "idle1");

        // single block, partial never shows as stored
        step(0, 1, 32'hAAAAAAAA, 0, '0, 1, 0, 0, "ad_w1");
        step(0, 1, 32'hBBBBBBBB, 0, '0, 1, 0, 0, "ad_w2");
        step(0, 1, 32'hCCCCCCCC, 0, '0, 1, 0, 0, "ad_w3");
        step(0, 1, 32'hDDDDDDDD, 0, '0, 0, 0, 1, "ad_w4");
        step(0, 0, 0, 1, b_ad, 1, 0, 0, "ad_rd");

        // fill to full, overflow word dropped, drain past empty
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 32'(i), 0, b_ad, (i < 4), (i == 8), (i / 4), $sformatf("fill_w%0d", i));
        end
        step(0, 1, 32'hFF, 0, b_ad, 0, 1, 2, "ovf_drop");
        step(0, 0, 0, 1, b_14, 0, 0, 1, "drain1");
        step(0, 0, 0, 1, b_58, 1, 0, 0, "drain2");
        step(0, 0, 0, 1, b_58, 1, 0, 0, "rd_empty_hold");

        // full with simultaneous read and write: read wins, word dropped
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32'(32'h10 + i), 0, b_58, (i < 3), (i == 7), ((i + 1) / 4),
                 $sformatf("full2_w%0d", i));
        end
        step(0, 1, 32'hEE, 1, b_10, 0, 0, 1, "full_rw");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'(32'h20 + i), 0, b_10, 0, (i == 3), (i == 3) ? 2 : 1,
                 $sformatf("refill_w%0d", i));
        end
        step(0, 0, 0, 1, b_14b, 0, 0, 1, "rd_b14");
        step(0, 0, 0, 1, b_20, 1, 0, 0, "rd_b20");

        // empty with simultaneous commit and read: commit wins, read ignored
        step(0, 1, 32'h30, 0, b_20, 1, 0, 0, "ec_w0");
        step(0, 1, 32'h31, 0, b_20, 1, 0, 0, "ec_w1");
        step(0, 1, 32'h32, 0, b_20, 1, 0, 0, "ec_w2");
        step(0, 1, 32'h33, 1, b_20, 0, 0, 1, "ec_commit_rd");
        step(0, 0, 0, 1, b_30, 1, 0, 0, "ec_rd");

        // reset mid-block discards the partial words
        step(0, 1, 32'h11111111, 0, b_30, 1, 0, 0, "mr_w1");
        step(0, 1, 32'h22222222, 0, b_30, 1, 0, 0, "mr_w2");
        step(1, 1, 32'h99, 1, '0, 1, 0, 0, "mr_rst");
        for (int i = 3; i <= 6; i++) begin
            step(0, 1, 32'(i), 0, '0, (i < 6), 0, (i == 6) ? 1 : 0, $sformatf("mr_w%0d", i));
        end
        step(0, 0, 0, 1, b_36, 1, 0, 0, "mr_rd");

        // interleaved write and read across pointer wrap
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'(32'h41 + i), 0, b_36, (i < 3), 0, (i == 3) ? 1 : 0,
                 $sformatf("il_w%0d", i + 1));
        end
        step(0, 1, 32'h45, 1, b_41, 1, 0, 0, "il_w5_rd");
        step(0, 1, 32'h46, 0, b_41, 1, 0, 0, "il_w6");
        step(0, 1, 32'h47, 0, b_41, 1, 0, 0, "il_w7");
        step(0, 1, 32'h48, 0, b_41, 0, 0, 1, "il_w8");
        step(0, 0, 0, 1, b_45, 1, 0, 0, "il_rd");

        write_en = 1'b0;
        read_en  = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge tb_clk);
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_in.md
# fifo_in

Input-side word packer and block buffer for the AES-128 datapath. Accepts 32-bit words from the host interface and assembles each group of four into a 128-bit block, first word in the most significant position. Queues up to DEPTH complete blocks and hands them to the cipher core one block per read. It is the write-narrow/read-wide counterpart of `fifo_out`, which unpacks 128-bit results back into 32-bit words.

## Interface
- DEPTH, 2, number of complete 128-bit blocks buffered (≥1)
- clk  input  1  system clock, all state updates on rising edge
- n_rst  input  1  synchronous active-low reset
- write_en  input  1  push one 32-bit word this cycle
- data_in  input  32  word to push
- read_en  input  1  pop one complete 128-bit block this cycle
- data_out  output  128  last popped block (registered)
- fifo_empty  output  1  no complete block stored
- fifo_full  output  1  all DEPTH block slots hold complete blocks; words refused
- block_count  output  $clog2(DEPTH+1)  number of complete blocks stored

## Operation
- Reset (n_rst low at a clk edge) has the following effects:
  - data_out=0, fifo_empty=1, fifo_full=0, block_count=0.
  - Packer returns to WORD0; the partial block is discarded.
  - Read and write pointers go to 0. Storage contents are don't-care.
- Packer FSM states are WORD0, WORD1, WORD2 and WORD3 (the index of the next word).
  - An accepted write in WORDk stores data_in in assembly bits [127-32k -: 32], then advances to WORD(k+1).
  - From WORD3, an accepted write commits {word0,word1,word2,data_in} to slot wr_ptr. It then increments wr_ptr modulo DEPTH and returns to WORD0.
- Write accepted iff write_en && !fifo_full, where fifo_full is the registered value. A refused write is dropped: no state change, no error flag.
- Read accepted iff read_en && !fifo_empty, where fifo_empty is the registered value.
  - An accepted read loads data_out <= slot[rd_ptr] and increments rd_ptr modulo DEPTH.
  - data_out otherwise holds its value.
  - A read while empty is ignored and data_out holds.
- block_count changes as follows:
  - +1 on commit only.
  - −1 on accepted read only.
  - Unchanged when a commit and an accepted read occur in the same cycle.
- Flags are derived from block_count and are registered:
  - fifo_empty = (block_count==0).
  - fifo_full = (block_count==DEPTH).
- A partial block (packer not in WORD0) never affects fifo_empty or block_count.
- Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.

## Timing
- Word-to-block latency: if the 4th word is accepted at edge N, then after edge N block_count has incremented and fifo_empty=0.
- The earliest read is accepted at edge N+1, and data_out is valid after N+1.
- Read latency: data_out updates on the same edge that accepts read_en. There is no show-ahead.
- Full, commit and read on the same edge:
  - The write is refused because the registered flag is full.
  - The read proceeds.
  - fifo_full deasserts after that edge.
  - The write must be reissued on the next cycle.
- Packer in WORD0–WORD2 and fifo_full=1: writes are still refused. Packing does not continue into the assembly register while full.
- Empty, commit and read_en on the same edge:
  - The read is refused because the registered flag is empty.
  - The commit proceeds.
  - After the edge, fifo_empty=0 and block_count=1.
- Reset mid-block or mid-stream: all state clears on the edge n_rst is sampled low. Any write_en or read_en on that edge is ignored.

## Structure
- Shared package aes_fifo_pkg holds:
  - WORD_W=32, BLOCK_W=128, WORDS_PER_BLOCK=4.
  - A packer state enum {WORD0,WORD1,WORD2,WORD3}.
  - This package is shared with `fifo_out`.
- Sub-module word_packer contains the FSM and the 96-bit partial register.
  - Inputs: clk, n_rst, push, word.
  - Outputs: block (128-bit) and block_valid, a one-cycle pulse on commit.
- The top level holds the slot array, the pointers, block_count and the flags.

## Test plan
- Reset, then idle 2 cycles -> fifo_empty=1, fifo_full=0, block_count=0, data_out=0.
- Write AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD on consecutive cycles, then one read.
  - fifo_empty=1 after words 1–3; fifo_empty=0 after word 4.
  - After the read: data_out=AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD, fifo_empty=1.
- With DEPTH=2, write 8 words 00000001..00000008, then 1 more word 000000FF.
  - fifo_full=1 and block_count=2; the 9th word is dropped.
  - Read twice: data_out=00000001000000020000000300000004, then 00000005000000060000000700000008.
  - Third read ignored; data_out holds 0000000500000006....
- Full FIFO: read_en and write_en asserted on the same edge -> read accepted, write dropped, block_count=1, fifo_full=0 after the edge.
- Write 2 words (11111111, 22222222), assert n_rst low for 1 cycle, then write 4 words 3..6.
  - The block read out is 00000003000000040000000500000006, with no remnant of the pre-reset words.
- Interleave: write 4 words, then write 4 more while reading once at word 5 -> block_count=1 after word 8, pointers wrap correctly, second read returns the second block.
